// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the core memory subsystem.
// Holds the requester ids used by the arbiter, the response-owner
// encoding, and the memory geometry shared with the core and the
// memory array.
package mem_pkg;

  localparam int MEM_ADDR_W = 10;
  localparam int WORD_W     = 32;

  // Requester ids; also used as bit positions in the arbiter's req/gnt vectors.
  localparam logic FETCH = 1'b0;
  localparam logic DATA  = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESP_IF = 2'd1,
    RESP_D  = 2'd2
  } resp_state_e;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin picker, purely combinational.
// Ports:
//   req[1:0]  in   request vector, bit FETCH / bit DATA
//   last      in   id of the most recently granted requester
//   gnt[1:0]  out  one-hot grant, or zero when nothing is requested
module rr_arb2
  import mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      // On a conflict the requester that did not win last time goes first.
      2'b11:   gnt = (last == DATA) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port word-addressed memory between the
// instruction fetch port (if_*) and the load/store port (d_*).
// Grants are combinational (round-robin on conflict); read data returns one
// cycle after the grant and is routed to the requester that owned the access.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no access issued last cycle, no response this cycle
// RESP_IF | fetch access issued last cycle, mem_rdata belongs to fetch
// RESP_D  | data access issued last cycle, load data or store ack for d_*
//
// Ports:
//   clk, rst                          clock, async active-high reset
//   if_req/if_addr -> if_gnt          fetch request and same-cycle grant
//   if_rvalid/if_rdata                fetch response (one cycle after grant)
//   d_req/d_we/d_be/d_addr/d_wdata    data request payload
//   d_gnt, d_rvalid/d_rdata           data grant and response (0 data on store ack)
//   mem_en/we/be/addr/wdata           memory port drive for the granted access
//   mem_rdata                         memory read data, one cycle after mem_en
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = WORD_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_W-1:0]     if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [DATA_W/8-1:0]   d_be,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  logic [1:0]  gnt;
  logic        last_gnt_q, last_gnt_d;
  resp_state_e resp_state_q, resp_state_d;
  logic        d_store_q, d_store_d;

  // Responses are always delivered in the cycle after the grant, so a
  // requester is never pending when it asks again; every request is eligible.
  rr_arb2 u_arb (
    .req  ({d_req, if_req}),
    .last (last_gnt_q),
    .gnt  (gnt)
  );

  assign if_gnt = gnt[FETCH];
  assign d_gnt  = gnt[DATA];

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_be    = d_we ? d_be : '0;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (if_gnt) begin
      mem_en    = 1'b1;
      mem_addr  = if_addr;
    end
  end

  always_comb begin
    last_gnt_d   = last_gnt_q;
    resp_state_d = IDLE;
    d_store_d    = d_store_q;
    if (if_gnt) begin
      last_gnt_d   = FETCH;
      resp_state_d = RESP_IF;
    end else if (d_gnt) begin
      last_gnt_d   = DATA;
      resp_state_d = RESP_D;
      d_store_d    = d_we;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt_q   <= FETCH;
      resp_state_q <= IDLE;
      d_store_q    <= 1'b0;
    end else begin
      last_gnt_q   <= last_gnt_d;
      resp_state_q <= resp_state_d;
      d_store_q    <= d_store_d;
    end
  end

  // rvalids decode straight from the state flop, so they drop the moment
  // reset is asserted.
  assign if_rvalid = (resp_state_q == RESP_IF);
  assign d_rvalid  = (resp_state_q == RESP_D);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = (d_rvalid && !d_store_q) ? mem_rdata : '0;

endmodule
